// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencing controller.
package alu_ctrl_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TAG_W  = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
        logic [TAG_W-1:0]  tag;
    } req_t;

    // Codes above OP_DIV are reserved and answered with an error response.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op <= OP_DIV);
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO for alu_seq_ctrl.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push, din  : write request (ignored when full)
//   pop        : remove head (ignored when empty)
//   head_c     : current head entry, combinational read of storage
//   full, empty, count : registered occupancy status
module alu_req_fifo
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  req_t                         din,
    output req_t                         head_c,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [CNT_W-1:0] count_nxt;

    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    assign head_c    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the 16-bit combinational ALU.
// Buffers requests, issues one at a time holding operands for the op's
// latency, and returns a tagged result over a valid/ready response port.
//   req_*  : request handshake and payload (op, rs1, rs2, tag)
//   alu_*  : drive to / result from the external ALU
//   rsp_*  : response handshake and payload (result, tag, err)
//   busy   : FIFO non-empty or controller not idle
// Build option: define ALU_DIVZERO_CHK_EN to answer DIV by zero with
// result 16'hFFFF / err=1 without issuing it to the ALU.
module alu_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_rs1,
    input  logic [DATA_W-1:0] req_rs2,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [OP_W-1:0]   alu_op_code,
    output logic [DATA_W-1:0] alu_rs1,
    output logic [DATA_W-1:0] alu_rs2,
    output logic              alu_cin,
    output logic              alu_bin,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int unsigned FCNT_W  = $clog2(DEPTH + 1);

    state_t            state, state_nxt;
    logic [LAT_W-1:0]  cnt, cnt_nxt;
    logic [OP_W-1:0]   alu_op_code_nxt;
    logic [DATA_W-1:0] alu_rs1_nxt, alu_rs2_nxt;
    logic              rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_result_nxt;
    logic [TAG_W-1:0]  rsp_tag_nxt;
    logic              rsp_err_nxt;
    logic              busy_nxt;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    logic [FCNT_W-1:0] fifo_count_nxt;
    req_t              fifo_head_c;
    req_t              req_word;

    logic              load;
    logic              head_divzero_c;
    logic              head_issue_c;
    logic [DATA_W-1:0] bypass_result_c;

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign req_word  = '{op: req_op, rs1: req_rs1, rs2: req_rs2, tag: req_tag};
    assign alu_cin   = 1'b0;
    assign alu_bin   = 1'b0;

    alu_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (req_word),
        .head_c (fifo_head_c),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

`ifdef ALU_DIVZERO_CHK_EN
    assign head_divzero_c  = (fifo_head_c.op == OP_DIV) && (fifo_head_c.rs2 == '0);
    assign bypass_result_c = head_divzero_c ? 16'hFFFF : 16'h0000;
`else
    assign head_divzero_c  = 1'b0;
    assign bypass_result_c = 16'h0000;
`endif

    assign head_issue_c = op_legal(fifo_head_c.op) && !head_divzero_c;

    // Remaining EXEC cycles after the first one.
    function automatic logic [LAT_W-1:0] lat_m1(input logic [OP_W-1:0] op);
        case (op)
            OP_MUL:  return LAT_W'(MUL_LAT - 1);
            OP_DIV:  return LAT_W'(DIV_LAT - 1);
            default: return '0;
        endcase
    endfunction

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        alu_op_code_nxt = alu_op_code;
        alu_rs1_nxt     = alu_rs1;
        alu_rs2_nxt     = alu_rs2;
        rsp_valid_nxt   = rsp_valid;
        rsp_result_nxt  = rsp_result;
        rsp_tag_nxt     = rsp_tag;
        rsp_err_nxt     = rsp_err;
        load            = 1'b0;
        fifo_pop        = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            EXEC: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - LAT_W'(1);
                end else begin
                    rsp_result_nxt  = alu_result;
                    rsp_err_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    alu_op_code_nxt = '0;
                    alu_rs1_nxt     = '0;
                    alu_rs2_nxt     = '0;
                    state_nxt       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    if (!fifo_empty) load = 1'b1;
                    else             state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Pop the head: issue it to the ALU, or answer it directly.
        if (load) begin
            fifo_pop    = 1'b1;
            rsp_tag_nxt = fifo_head_c.tag;
            if (head_issue_c) begin
                state_nxt       = EXEC;
                cnt_nxt         = lat_m1(fifo_head_c.op);
                alu_op_code_nxt = fifo_head_c.op;
                alu_rs1_nxt     = fifo_head_c.rs1;
                alu_rs2_nxt     = fifo_head_c.rs2;
            end else begin
                state_nxt      = RESP;
                rsp_valid_nxt  = 1'b1;
                rsp_result_nxt = bypass_result_c;
                rsp_err_nxt    = 1'b1;
            end
        end

        fifo_count_nxt = fifo_count + FCNT_W'(fifo_push) - FCNT_W'(fifo_pop);
        busy_nxt       = (fifo_count_nxt != '0) || (state_nxt != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            alu_op_code <= '0;
            alu_rs1     <= '0;
            alu_rs2     <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_tag     <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            alu_op_code <= alu_op_code_nxt;
            alu_rs1     <= alu_rs1_nxt;
            alu_rs2     <= alu_rs2_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_result  <= rsp_result_nxt;
            rsp_tag     <= rsp_tag_nxt;
            rsp_err     <= rsp_err_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural ALU beside it.
module tb_alu_seq_ctrl;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned DIV_LAT = 4;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_rs1, req_rs2;
    logic [3:0]  req_tag;
    logic [3:0]  alu_op_code;
    logic [15:0] alu_rs1, alu_rs2;
    logic        alu_cin, alu_bin;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic        busy;

    int   checks = 0;
    int   fails  = 0;
    exp_t exp_q[$];
    exp_t e;

    alu_seq_ctrl #(
        .DEPTH   (DEPTH),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_tag     (req_tag),
        .alu_op_code (alu_op_code),
        .alu_rs1     (alu_rs1),
        .alu_rs2     (alu_rs2),
        .alu_cin     (alu_cin),
        .alu_bin     (alu_bin),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_tag     (rsp_tag),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Combinational ALU; divide by zero returns all ones.
    always_comb begin
        case (alu_op_code)
            4'd0:    alu_result = 16'(alu_rs1 + alu_rs2);
            4'd1:    alu_result = 16'(alu_rs1 - alu_rs2);
            4'd2:    alu_result = 16'(alu_rs1 * alu_rs2);
            4'd3:    alu_result = (alu_rs2 == 16'd0) ? 16'hFFFF : 16'(alu_rs1 / alu_rs2);
            default: alu_result = 16'd0;
        endcase
    end

    // Expected response from the operation's definition.
    function automatic exp_t ref_rsp(input logic [3:0] op, input logic [15:0] a,
                                     input logic [15:0] b, input logic [3:0] tag);
        exp_t        r;
        int unsigned ua;
        int unsigned ub;
        ua    = a;
        ub    = b;
        r.tag = tag;
        r.err = 1'b0;
        r.res = 16'd0;
        case (op)
            4'd0: r.res = 16'((ua + ub) % 65536);
            4'd1: r.res = 16'((ua + 65536 - ub) % 65536);
            4'd2: r.res = 16'((ua * ub) % 65536);
            4'd3: begin
                if (ub == 0) begin
                    r.res = 16'hFFFF;
`ifdef ALU_DIVZERO_CHK_EN
                    r.err = 1'b1;
`endif
                end else begin
                    r.res = 16'(ua / ub);
                end
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [3:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tag;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        step();
        step();
        checks++;
        if ({rsp_valid, rsp_result, rsp_tag, rsp_err, busy, alu_op_code, alu_rs1, alu_rs2,
             alu_cin, alu_bin} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%0b res=%h tag=%0d err=%0b busy=%0b op=%0d rs1=%h rs2=%h, want all 0",
                     rsp_valid, rsp_result, rsp_tag, rsp_err, busy, alu_op_code, alu_rs1, alu_rs2);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        rsp_ready = 1'b1;
        drive_req(4'd0, 16'h0003, 16'h0005, 4'd2);
        step();                                // edge N: accepted
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL add_n_valid: got %b want 0", rsp_valid); end
        step();                                // edge N+1: popped, EXEC
        checks++;
        if ({rsp_valid, alu_rs1, alu_rs2} !== {1'b0, 16'h0003, 16'h0005}) begin
            fails++;
            $display("FAIL add_exec: valid=%b rs1=%h rs2=%h want 0/0003/0005", rsp_valid, alu_rs1, alu_rs2);
        end
        step();                                // edge N+2: captured
        checks++;
        if ({rsp_valid, rsp_result, rsp_tag, rsp_err} !== {1'b1, 16'h0008, 4'd2, 1'b0}) begin
            fails++;
            $display("FAIL add_resp: valid=%b res=%h tag=%0d err=%b want 1/0008/2/0",
                     rsp_valid, rsp_result, rsp_tag, rsp_err);
        end
        checks++;
        if ({alu_op_code, alu_rs1, alu_rs2} !== '0) begin
            fails++;
            $display("FAIL add_alu_idle: op=%0d rs1=%h rs2=%h want 0", alu_op_code, alu_rs1, alu_rs2);
        end
        step();
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL add_done: valid=%b busy=%b want 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_mul_div();
        int mul_cyc = 0;
        int div_cyc = 0;
        int n_rsp   = 0;
        int rsp_cyc [2];
        logic [15:0] rsp_res [2];
        logic [3:0]  rsp_tg  [2];
        rsp_ready = 1'b1;
        drive_req(4'd2, 16'd7, 16'd6, 4'd3);
        step();                                // edge N
        drive_req(4'd3, 16'd100, 16'd7, 4'd4);
        step();                                // edge N+1
        req_valid = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) step();
            if (alu_op_code == 4'd2 && alu_rs1 == 16'd7 && alu_rs2 == 16'd6) mul_cyc++;
            if (alu_op_code == 4'd3 && alu_rs1 == 16'd100 && alu_rs2 == 16'd7) div_cyc++;
            if (rsp_valid && rsp_ready && n_rsp < 2) begin
                rsp_cyc[n_rsp] = c;
                rsp_res[n_rsp] = rsp_result;
                rsp_tg[n_rsp]  = rsp_tag;
                n_rsp++;
            end
        end
        checks++;
        if (mul_cyc != MUL_LAT) begin fails++; $display("FAIL mul_hold: got %0d cycles want %0d", mul_cyc, MUL_LAT); end
        checks++;
        if (div_cyc != DIV_LAT) begin fails++; $display("FAIL div_hold: got %0d cycles want %0d", div_cyc, DIV_LAT); end
        checks++;
        if (n_rsp != 2) begin
            fails++;
            $display("FAIL muldiv_count: got %0d responses want 2", n_rsp);
        end else begin
            checks++;
            if (rsp_cyc[0] != 3 || rsp_res[0] !== 16'd42 || rsp_tg[0] !== 4'd3) begin
                fails++;
                $display("FAIL mul_resp: edge N+%0d res=%0d tag=%0d want N+3/42/3", rsp_cyc[0], rsp_res[0], rsp_tg[0]);
            end
            checks++;
            if (rsp_cyc[1] != 4 + DIV_LAT || rsp_res[1] !== 16'd14 || rsp_tg[1] !== 4'd4) begin
                fails++;
                $display("FAIL div_resp: edge N+%0d res=%0d tag=%0d want N+%0d/14/4",
                         rsp_cyc[1], rsp_res[1], rsp_tg[1], 4 + DIV_LAT);
            end
        end
    endtask

    task automatic test_full();
        int          accepted = 0;
        logic        was;
        logic [15:0] a, b;
        exp_q.delete();
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = 16'(16'h1111 * (accepted + 1));
            b = 16'(accepted + 7);
            drive_req(4'd0, a, b, 4'(accepted + 1));
            was = req_ready;
            step();
            if (was) begin
                exp_q.push_back(ref_rsp(4'd0, a, b, 4'(accepted + 1)));
                accepted++;
            end
        end
        checks++;
        if (accepted != DEPTH + 1) begin fails++; $display("FAIL full_accepted: got %0d want %0d", accepted, DEPTH + 1); end
        checks++;
        if (req_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", req_ready); end
        e = exp_q.pop_front();
        checks++;
        if ({rsp_valid, rsp_result, rsp_tag, rsp_err} !== {1'b1, e.res, e.tag, e.err}) begin
            fails++;
            $display("FAIL full_stall_hold: valid=%b res=%h tag=%0d err=%b want 1/%h/%0d/%b",
                     rsp_valid, rsp_result, rsp_tag, rsp_err, e.res, e.tag, e.err);
        end
        rsp_ready = 1'b1;
        was = req_ready;
        step();                                // first response consumed
        rsp_ready = 1'b0;
        checks++;
        if (was !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_release: ready before=%b after=%b want 0/1", was, req_ready);
        end
        a   = req_rs1;
        b   = req_rs2;
        was = req_ready;
        step();
        if (was) exp_q.push_back(ref_rsp(4'd0, a, b, 4'(accepted + 1)));
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL full_extra: unexpected response tag=%0d", rsp_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_result, rsp_tag, rsp_err} !== {e.res, e.tag, e.err}) begin
                        fails++;
                        $display("FAIL full_order: res=%h tag=%0d err=%b want %h/%0d/%b",
                                 rsp_result, rsp_tag, rsp_err, e.res, e.tag, e.err);
                    end
                end
            end
            if (exp_q.size() == 0 && !busy) break;
            step();
        end
        checks++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL full_drain: %0d responses missing", exp_q.size()); end
    endtask

    task automatic test_illegal();
        logic op_seen = 1'b0;
        rsp_ready = 1'b1;
        drive_req(4'd9, 16'h1234, 16'h5678, 4'd5);
        step();                                // edge N
        req_valid = 1'b0;
        if (alu_op_code != 4'd0) op_seen = 1'b1;
        checks++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL illegal_early: valid=%b want 0", rsp_valid); end
        step();                                // edge N+1: popped straight to response
        if (alu_op_code != 4'd0) op_seen = 1'b1;
        checks++;
        if ({rsp_valid, rsp_result, rsp_tag, rsp_err} !== {1'b1, 16'h0000, 4'd5, 1'b1}) begin
            fails++;
            $display("FAIL illegal_resp: valid=%b res=%h tag=%0d err=%b want 1/0000/5/1",
                     rsp_valid, rsp_result, rsp_tag, rsp_err);
        end
        step();
        if (alu_op_code != 4'd0) op_seen = 1'b1;
        checks++;
        if ({rsp_valid, busy, op_seen} !== 3'b000) begin
            fails++;
            $display("FAIL illegal_after: valid=%b busy=%b alu_op_seen=%b want 0/0/0", rsp_valid, busy, op_seen);
        end
    endtask

    task automatic test_divzero();
        int   first  = -1;
        int   div_cyc = 0;
        int   want_first;
        int   want_div;
        exp_t w;
`ifdef ALU_DIVZERO_CHK_EN
        want_first = 1;
        want_div   = 0;
`else
        want_first = 1 + DIV_LAT;
        want_div   = DIV_LAT;
`endif
        w = ref_rsp(4'd3, 16'd50, 16'd0, 4'd6);
        rsp_ready = 1'b1;
        drive_req(4'd3, 16'd50, 16'd0, 4'd6);
        step();                                // edge N
        req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (alu_op_code == 4'd3) div_cyc++;
            if (rsp_valid && first < 0) begin
                first = c;
                checks++;
                if ({rsp_result, rsp_tag, rsp_err} !== {w.res, w.tag, w.err}) begin
                    fails++;
                    $display("FAIL divzero_resp: res=%h tag=%0d err=%b want %h/%0d/%b",
                             rsp_result, rsp_tag, rsp_err, w.res, w.tag, w.err);
                end
            end
        end
        checks++;
        if (first != want_first || div_cyc != want_div) begin
            fails++;
            $display("FAIL divzero_timing: resp at N+%0d exec=%0d want N+%0d exec=%0d",
                     first, div_cyc, want_first, want_div);
        end
    endtask

    task automatic test_reset_mid();
        logic seen_valid = 1'b0;
        logic seen_busy  = 1'b0;
        rsp_ready = 1'b0;
        drive_req(4'd3, 16'd100, 16'd7, 4'd7);
        step();
        for (int i = 0; i < 3; i++) begin
            drive_req(4'd0, 16'(i), 16'(i + 1), 4'(8 + i));
            step();
        end
        req_valid = 1'b0;
        checks++;
        if ({alu_op_code, busy} !== {4'd3, 1'b1}) begin
            fails++;
            $display("FAIL midrst_pre: op=%0d busy=%b want 3/1", alu_op_code, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_result, rsp_tag, rsp_err, busy, alu_op_code, alu_rs1, alu_rs2,
             alu_cin, alu_bin} !== '0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrst_async: valid=%b res=%h tag=%0d err=%b busy=%b op=%0d rs1=%h rs2=%h ready=%b",
                     rsp_valid, rsp_result, rsp_tag, rsp_err, busy, alu_op_code, alu_rs1, alu_rs2, req_ready);
        end
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            seen_valid |= rsp_valid;
            seen_busy  |= busy;
        end
        checks++;
        if ({seen_valid, seen_busy} !== 2'b00) begin
            fails++;
            $display("FAIL midrst_stale: valid_seen=%b busy_seen=%b want 0/0", seen_valid, seen_busy);
        end
    endtask

    task automatic test_random();
        logic        hold_chk = 1'b0;
        logic [15:0] h_res;
        logic [3:0]  h_tag;
        logic        h_err;
        int unsigned r;
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            if (hold_chk) begin
                checks++;
                if ({rsp_valid, rsp_result, rsp_tag, rsp_err} !== {1'b1, h_res, h_tag, h_err}) begin
                    fails++;
                    $display("FAIL rand_hold: valid=%b res=%h tag=%0d err=%b want 1/%h/%0d/%b",
                             rsp_valid, rsp_result, rsp_tag, rsp_err, h_res, h_tag, h_err);
                end
            end
            r = $urandom_range(0, 7);
            req_valid = ($urandom_range(0, 1) == 1);
            req_op    = (r < 6) ? 4'(r % 4) : 4'($urandom_range(4, 15));
            req_rs1   = 16'($urandom);
            req_rs2   = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(0, 300));
            req_tag   = 4'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            if (req_valid && req_ready) exp_q.push_back(ref_rsp(req_op, req_rs1, req_rs2, req_tag));
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_extra: unexpected response tag=%0d", rsp_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_result, rsp_tag, rsp_err} !== {e.res, e.tag, e.err}) begin
                        fails++;
                        $display("FAIL rand_rsp: res=%h tag=%0d err=%b want %h/%0d/%b",
                                 rsp_result, rsp_tag, rsp_err, e.res, e.tag, e.err);
                    end
                end
            end
            hold_chk = rsp_valid && !rsp_ready;
            h_res    = rsp_result;
            h_tag    = rsp_tag;
            h_err    = rsp_err;
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_extra: unexpected response tag=%0d", rsp_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_result, rsp_tag, rsp_err} !== {e.res, e.tag, e.err}) begin
                        fails++;
                        $display("FAIL rand_drain: res=%h tag=%0d err=%b want %h/%0d/%b",
                                 rsp_result, rsp_tag, rsp_err, e.res, e.tag, e.err);
                    end
                end
            end
            if (exp_q.size() == 0 && !rsp_valid && !busy) break;
            step();
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rand_timeout: %0d responses missing, busy=%b", exp_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_div();
        test_full();
        test_illegal();
        test_divzero();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
